// File: rtl/insn_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches and buffers responses.
// Define INSN_PREFETCH_BYPASS_EN to forward a response straight out when empty.
module insn_prefetch_queue #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [AWIDTH-1:0] BASEADDR = 'h01000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run_i,
  input  logic                       redirect_i,
  input  logic [AWIDTH-1:0]          redirect_pc_i,
  output logic                       mem_read_en_o,
  output logic [AWIDTH-1:0]          mem_addr_o,
  input  logic [DWIDTH-1:0]          mem_data_i,
  output logic                       insn_valid_o,
  output logic [DWIDTH-1:0]          insn_o,
  output logic [AWIDTH-1:0]          pc_o,
  input  logic                       insn_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] fpc_q;
  logic [AWIDTH-1:0] rpc_q;
  logic              infl_q;
  logic              disc_q;
  logic [PW-1:0]     rptr_q;
  logic [PW-1:0]     wptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DWIDTH-1:0] data_q [DEPTH];
  logic [AWIDTH-1:0] pcs_q  [DEPTH];

  logic              issue;
  logic              resp_v;
  logic              push;
  logic              pop;
  logic [CW:0]       occ;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run_i) state_d = RUN;
      RUN:     if (!run_i) state_d = IDLE;
      FLUSH:   state_d = run_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect_i) state_d = FLUSH;
  end

  // Reserve a slot for the in-flight response so it can never overflow.
  assign occ = {1'b0, cnt_q} + (CW+1)'(infl_q);
  assign issue = rst && (state_q == RUN) && !redirect_i
              && (occ < (CW+1)'(DEPTH));
  assign resp_v = infl_q && !disc_q && !redirect_i;

  assign mem_read_en_o = issue;
  assign mem_addr_o    = fpc_q;
  assign count_o       = cnt_q;

`ifdef INSN_PREFETCH_BYPASS_EN
  logic byp;
  assign byp = resp_v && (cnt_q == '0);
  assign insn_valid_o = !redirect_i && ((cnt_q != '0) || byp);
  assign insn_o = byp ? mem_data_i : data_q[rptr_q];
  assign pc_o   = byp ? rpc_q : pcs_q[rptr_q];
  assign push = resp_v && !(byp && insn_ready_i);
  assign pop  = insn_valid_o && insn_ready_i && !byp;
`else
  assign insn_valid_o = !redirect_i && (cnt_q != '0);
  assign insn_o = data_q[rptr_q];
  assign pc_o   = pcs_q[rptr_q];
  assign push = resp_v;
  assign pop  = insn_valid_o && insn_ready_i;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      fpc_q   <= BASEADDR;
      rpc_q   <= BASEADDR;
      infl_q  <= 1'b0;
      disc_q  <= 1'b0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      infl_q  <= issue;
      disc_q  <= redirect_i;
      if (issue) begin
        rpc_q <= fpc_q;
        fpc_q <= fpc_q + AWIDTH'(4);
      end
      if (redirect_i) begin
        fpc_q  <= redirect_pc_i & ~AWIDTH'(3);
        rptr_q <= '0;
        wptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PW'(1);
        if (pop) rptr_q <= rptr_q + PW'(1);
        cnt_q <= cnt_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wptr_q] <= mem_data_i;
      pcs_q[wptr_q]  <= rpc_q;
    end
  end

endmodule

// File: doc/insn_prefetch_queue.md
INSN_PREFETCH_QUEUE -- requirements
Module: insn_prefetch_queue

Interface
REQ-001 Parameter AWIDTH, default 32, address and PC width.
REQ-002 Parameter DWIDTH, default 32, instruction width.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-004 Parameter BASEADDR, default 32'h01000000, first fetch address after reset.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 run_i  in  1  permit issuing new fetch requests.
REQ-008 redirect_i  in  1  flush the queue and restart fetch at redirect_pc_i.
REQ-009 redirect_pc_i  in  AWIDTH  restart address; bits [1:0] SHALL be treated as zero.
REQ-010 mem_read_en_o  out  1  fetch request to instruction memory.
REQ-011 mem_addr_o  out  AWIDTH  fetch address; valid while mem_read_en_o=1.
REQ-012 mem_data_i  in  DWIDTH  read data, valid exactly one cycle after the request.
REQ-013 insn_valid_o  out  1  head entry valid.
REQ-014 insn_o  out  DWIDTH  head instruction.
REQ-015 pc_o  out  AWIDTH  address from which insn_o was fetched.
REQ-016 insn_ready_i  in  1  consumer accepts the head entry when insn_valid_o=1.
REQ-017 count_o  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and FLUSH.
REQ-019 Transitions: IDLE->RUN when run_i=1; RUN->IDLE when run_i=0; any state->FLUSH when redirect_i=1; FLUSH->RUN if run_i=1, else IDLE, after one cycle.
REQ-020 mem_read_en_o SHALL equal 1 only when state=RUN, redirect_i=0 and count + in-flight < DEPTH; at most one request is in flight.
REQ-021 mem_addr_o SHALL equal the fetch PC register; the register increments by 4 per issued request, wrapping modulo 2^AWIDTH.
REQ-022 A response SHALL be written at the tail with the PC of its request, unless it is discarded.
REQ-023 On redirect_i=1: queue emptied, fetch PC loaded with {redirect_pc_i[AWIDTH-1:2],2'b00}, and any response arriving the next cycle discarded.
REQ-024 insn_valid_o SHALL be forced 0 in any cycle with redirect_i=1; redirect takes priority over the handshake.
REQ-025 A pop occurs when insn_valid_o=1 and insn_ready_i=1; a simultaneous push and pop SHALL leave count_o unchanged.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 count_o SHALL never exceed DEPTH, and no response is ever dropped except under REQ-023.
REQ-028 Deasserting run_i SHALL stop new requests only; an in-flight response still enqueues, and the queue keeps draining.
REQ-029 Latency without bypass: request in cycle N, insn_valid_o=1 with that entry in cycle N+2.

Reset
REQ-030 While rst=0 at a clock edge: state=IDLE, fetch PC=BASEADDR, queue empty, in-flight and discard flags cleared.
REQ-031 Outputs during and after reset: mem_read_en_o=0, mem_addr_o=BASEADDR, insn_valid_o=0, count_o=0; insn_o and pc_o are don't-care while insn_valid_o=0.
REQ-032 A reset asserted mid-operation SHALL drop all entries; the response to a request issued in the reset cycle SHALL be discarded.

Configuration
REQ-033 Macro INSN_PREFETCH_BYPASS_EN, when defined, SHALL present a non-discarded response on insn_o/pc_o with insn_valid_o=1 in its arrival cycle if the queue is empty; it is enqueued only if not accepted that cycle, giving latency N+1.
REQ-034 When INSN_PREFETCH_BYPASS_EN is undefined, every response SHALL pass through queue storage, with the latency of REQ-029.

Verification
REQ-035 Reset, run_i=1 held, insn_ready_i=1, memory returns addr^32'hFFFF0000 -> requests at 01000000, 01000004, ...; first insn_valid_o 2 cycles after first request, pc_o=01000000, insn_o=FEFF0000.
REQ-036 insn_ready_i=0, DEPTH=4 -> exactly 4 requests (01000000..0100000C), count_o=4, mem_read_en_o=0 thereafter; insn_ready_i=1 for one cycle -> count_o=3, then one request at 01000010.
REQ-037 redirect_i=1 with redirect_pc_i=01000103 while a request is in flight -> that cycle insn_valid_o=0; next cycle count_o=0 and the response is not enqueued; next request at 01000100.
REQ-038 Full queue with push and pop in the same cycle (DEPTH=2, steady ready toggling) -> count_o never exceeds 2, and the pc_o sequence is strictly +4 with no gaps or repeats.
REQ-039 rst=0 for one cycle mid-stream with 3 entries queued -> next cycle count_o=0, insn_valid_o=0, mem_addr_o=01000000.
REQ-040 With INSN_PREFETCH_BYPASS_EN defined, empty queue and insn_ready_i=1 -> insn_valid_o=1 in the cycle after the request, and count_o stays 0.
